// File: rtl/switcher.sv
// switcher: three-digit 7-segment driver with manual select or auto-scan multiplexing
module switcher #(
   parameter int SCAN_DIV = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] SEL,
   input  logic       AUTO,
   input  logic [3:0] DIG1,
   input  logic [3:0] DIG2,
   input  logic [3:0] DIG3,
   output logic       D1,
   output logic       D2,
   output logic       D3,
   output logic [6:0] SEG
);
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   logic [1:0]    idx;
   logic [PW-1:0] pre;
   logic [1:0]    pick;
   logic [3:0]    val;
   logic [6:0]    seg_next;
   // digit currently selected: scan index in auto mode, SEL otherwise; code 3 means blank
   always_comb begin
      pick = AUTO ? idx : SEL;
      val  = pick == 2'd0 ? DIG1 : pick == 2'd1 ? DIG2 : DIG3;
   end
   // hex to {g,f,e,d,c,b,a} decode of the selected digit value
   always_comb begin
      case (val)
         4'h0: seg_next = 7'h3F;
         4'h1: seg_next = 7'h06;
         4'h2: seg_next = 7'h5B;
         4'h3: seg_next = 7'h4F;
         4'h4: seg_next = 7'h66;
         4'h5: seg_next = 7'h6D;
         4'h6: seg_next = 7'h7D;
         4'h7: seg_next = 7'h07;
         4'h8: seg_next = 7'h7F;
         4'h9: seg_next = 7'h6F;
         4'hA: seg_next = 7'h77;
         4'hB: seg_next = 7'h7C;
         4'hC: seg_next = 7'h39;
         4'hD: seg_next = 7'h5E;
         4'hE: seg_next = 7'h79;
         default: seg_next = 7'h71;
      endcase
   end
   // scan prescaler and digit index advance only in auto mode and hold otherwise
   always_ff @(posedge CLK) begin
      if (RST) begin
         idx <= 2'd0;
         pre <= '0;
      end else if (AUTO) begin
         if (idx == 2'd3) begin
            idx <= 2'd0;
         end else if (pre == PRE_LAST) begin
            pre <= '0;
            idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
         end else begin
            pre <= pre + 1'b1;
         end
      end
   end
   // enables and segments registered together from one selection so they always agree
   always_ff @(posedge CLK) begin
      if (RST) begin
         D1  <= 1'b0;
         D2  <= 1'b0;
         D3  <= 1'b0;
         SEG <= 7'h00;
      end else begin
         D1  <= pick == 2'd0;
         D2  <= pick == 2'd1;
         D3  <= pick == 2'd2;
         SEG <= pick == 2'd3 ? 7'h00 : seg_next;
      end
   end
endmodule

// File: tb/tb_switcher.sv
// tb_switcher: directed checks of manual select, auto scan, reset and hex decode
module tb_switcher;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sel;
   logic       auto;
   logic [3:0] dig1, dig2, dig3;
   logic       a1, a2, a3, b1, b2, b3;
   logic [6:0] aseg, bseg;
   int total = 0;
   int bad = 0;
   int k;

   always #5 clk = ~clk;

   switcher #(.SCAN_DIV(4)) dut (
      .CLK(clk), .RST(rst), .SEL(sel), .AUTO(auto),
      .DIG1(dig1), .DIG2(dig2), .DIG3(dig3),
      .D1(a1), .D2(a2), .D3(a3), .SEG(aseg)
   );

   switcher #(.SCAN_DIV(1)) dut_fast (
      .CLK(clk), .RST(rst), .SEL(sel), .AUTO(auto),
      .DIG1(dig1), .DIG2(dig2), .DIG3(dig3),
      .D1(b1), .D2(b2), .D3(b3), .SEG(bseg)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[v];
   endfunction

   function automatic logic [9:0] expect_dig(input int d);
      logic [3:0] v;
      v = d == 0 ? dig1 : d == 1 ? dig2 : dig3;
      return {d == 0, d == 1, d == 2, seg_of(v)};
   endfunction

   task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic auto_step();
      step();
      chk("scan4", {a1, a2, a3, aseg}, expect_dig((k / 4) % 3));
      chk("scan1", {b1, b2, b3, bseg}, expect_dig(k % 3));
      chk("onehot4", 10'($countones({a1, a2, a3}) <= 1), 10'd1);
      k++;
   endtask

   initial begin
      rst = 1'b1; auto = 1'b1; sel = 2'b00;
      dig1 = 4'h1; dig2 = 4'h2; dig3 = 4'h3;
      step();
      chk("reset_prio", {a1, a2, a3, aseg}, 10'h000);
      auto = 1'b0;
      step();
      chk("reset", {a1, a2, a3, aseg}, 10'h000);
      rst = 1'b0;
      sel = 2'b00; step(); chk("man_d1", {a1, a2, a3, aseg}, {3'b100, 7'h06});
      sel = 2'b01; step(); chk("man_d2", {a1, a2, a3, aseg}, {3'b010, 7'h5B});
      sel = 2'b10; step(); chk("man_d3", {a1, a2, a3, aseg}, {3'b001, 7'h4F});
      sel = 2'b11; dig1 = 4'h8; step(); chk("man_off", {a1, a2, a3, aseg}, 10'h000);
      sel = 2'b00;
      for (int v = 0; v < 16; v++) begin
         dig1 = 4'(v);
         step();
         chk($sformatf("hex%0h", v), {a1, a2, a3, aseg}, {3'b100, seg_of(4'(v))});
      end
      chk("hexA_const", {a1, a2, a3, aseg}, {3'b100, 7'h71});
      dig1 = 4'hA; dig2 = 4'hB; dig3 = 4'hF;
      rst = 1'b1; step();
      chk("rst4", {a1, a2, a3, aseg}, 10'h000);
      chk("rst1", {b1, b2, b3, bseg}, 10'h000);
      rst = 1'b0; auto = 1'b1; k = 0;
      chk("fastA", expect_dig(0), {3'b100, 7'h77});
      for (int i = 0; i < 6; i++) auto_step();
      auto = 1'b0; sel = 2'b00;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hold4", {a1, a2, a3, aseg}, {3'b100, 7'h77});
         chk("hold1", {b1, b2, b3, bseg}, {3'b100, 7'h77});
      end
      auto = 1'b1;
      while (k < 22) auto_step();
      rst = 1'b1; step();
      chk("midrst4", {a1, a2, a3, aseg}, 10'h000);
      chk("midrst1", {b1, b2, b3, bseg}, 10'h000);
      rst = 1'b0; k = 0;
      for (int i = 0; i < 8; i++) auto_step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
